param_counter: RTL and testbench

Parametrised synchronous up/down counter, the general-purpose successor to the fixed 32-bit free-running counter used in simple testbenches. It adds configurable width and modulus, direction control, parallel load, synchronous clear, and wrap or saturate behaviour at the limits, with a one-cycle limit-event pulse. It is instantiated wherever the design needs event counting, timeouts or modulo sequencing.

---
 rtl/param_counter.sv | 114 +++++++++++
 tb/tb_param_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with load, clear and wrap/saturate limits.
// Optional sticky limit flag enabled by defining PARAM_COUNTER_STICKY_EN.
module param_counter #(
   parameter int                WIDTH     = 32,
   parameter logic [WIDTH-1:0]  MAX       = {WIDTH{1'b1}},
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter bit                SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clear,
   output logic [WIDTH-1:0] count,
   output logic             evt,
   output logic             at_max,
   output logic             at_min,
   output logic             sticky
);

   // Limit kept one bit wider so step results are compared before truncation.
   localparam logic [WIDTH:0] MAX_X = {1'b0, MAX};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             evt_q;
   logic             evt_d;
   logic [WIDTH:0]   count_x;
   logic [WIDTH:0]   inc_x;
   logic [WIDTH:0]   dec_x;
   logic             hit_top;
   logic             hit_bot;
   logic [WIDTH-1:0] load_clamped;

   // Widened step arithmetic and limit detection.
   always_comb begin
      count_x = {1'b0, count_q};
      inc_x   = count_x + {{WIDTH{1'b0}}, 1'b1};
      dec_x   = count_x - {{WIDTH{1'b0}}, 1'b1};
      hit_top = (inc_x > MAX_X);
      hit_bot = dec_x[WIDTH];
   end

   // Out-of-range load values are clamped to the terminal value.
   always_comb begin
      load_clamped = load_val;
      if (load_val > MAX) begin
         load_clamped = MAX;
      end
   end

   // Next-state selection, priority clear > load > step > hold.
   always_comb begin
      count_d = count_q;
      evt_d   = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_clamped;
      end else if (en) begin
         if (up) begin
            if (hit_top) begin
               evt_d   = 1'b1;
               count_d = SATURATE ? MAX : '0;
            end else begin
               count_d = inc_x[WIDTH-1:0];
            end
         end else begin
            if (hit_bot) begin
               evt_d   = 1'b1;
               count_d = SATURATE ? '0 : MAX;
            end else begin
               count_d = dec_x[WIDTH-1:0];
            end
         end
      end
   end

   // Count and event registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= RESET_VAL;
         evt_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         evt_q   <= evt_d;
      end
   end

`ifdef PARAM_COUNTER_STICKY_EN
   logic sticky_q;

   // Sticky flag latches any limit event until reset or clear.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sticky_q <= 1'b0;
      end else if (evt_d) begin
         sticky_q <= 1'b1;
      end
   end

   assign sticky = sticky_q;
`else
   assign sticky = 1'b0;
`endif

   assign count  = count_q;
   assign evt    = evt_q;
   assign at_max = (count_q == MAX);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_param_counter.sv
// Directed testbench for param_counter (WIDTH=4, MAX=9, RESET_VAL=3),
// one wrapping and one saturating instance sharing the same stimulus.
module tb_param_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load, clear;
   logic [3:0] load_val;
   logic [3:0] cw, cs;
   logic       ew, es, mxw, mxs, mnw, mns, sw, ss;
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   param_counter #(.WIDTH(4), .MAX(4'd9), .RESET_VAL(4'd3), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear(clear), .count(cw), .evt(ew), .at_max(mxw), .at_min(mnw), .sticky(sw)
   );

   param_counter #(.WIDTH(4), .MAX(4'd9), .RESET_VAL(4'd3), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .clear(clear), .count(cs), .evt(es), .at_max(mxs), .at_min(mns), .sticky(ss)
   );

`ifdef PARAM_COUNTER_STICKY_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; en = 0; up = 1; load = 0; clear = 0; load_val = 0;
   endtask

   task automatic do_load(input logic [3:0] v);
      idle(); load = 1; load_val = v;
      tick();
      load = 0;
   endtask

   task automatic test_reset();
      idle(); rst = 1; en = 1; up = 1;
      tick(); tick();
      tests++; if (cw !== 4'd3) begin fails++; $display("FAIL rst_count_w got %0d exp 3", cw); end
      tests++; if (cs !== 4'd3) begin fails++; $display("FAIL rst_count_s got %0d exp 3", cs); end
      tests++; if ({ew, mxw, mnw, sw} !== 4'b0000) begin fails++; $display("FAIL rst_flags got %b exp 0000", {ew, mxw, mnw, sw}); end
      rst = 0;
      tick();
      tests++; if (cw !== 4'd4) begin fails++; $display("FAIL rst_release got %0d exp 4", cw); end
   endtask

   task automatic test_wrap_up();
      do_load(4'd7);
      tests++; if (cw !== 4'd7) begin fails++; $display("FAIL load7 got %0d exp 7", cw); end
      en = 1; up = 1;
      tick();
      tests++; if ({cw, ew} !== {4'd8, 1'b0}) begin fails++; $display("FAIL wrap_c1 got %0d/%b exp 8/0", cw, ew); end
      tick();
      tests++; if ({cw, ew, mxw} !== {4'd9, 1'b0, 1'b1}) begin fails++; $display("FAIL wrap_c2 got %0d/%b/%b exp 9/0/1", cw, ew, mxw); end
      tick();
      tests++; if ({cw, ew, mxw, mnw} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin fails++; $display("FAIL wrap_c3 got %0d/%b/%b/%b exp 0/1/0/1", cw, ew, mxw, mnw); end
      tests++; if ({cs, es} !== {4'd9, 1'b1}) begin fails++; $display("FAIL sat_top got %0d/%b exp 9/1", cs, es); end
      tests++; if (sw !== STK) begin fails++; $display("FAIL sticky_wrap got %b exp %b", sw, STK); end
      en = 0;
      tick();
      tests++; if ({cw, ew} !== {4'd0, 1'b0}) begin fails++; $display("FAIL hold_after_wrap got %0d/%b exp 0/0", cw, ew); end
   endtask

   task automatic test_sticky();
      do_load(4'd5);
      tests++; if ({cw, sw} !== {4'd5, STK}) begin fails++; $display("FAIL sticky_load got %0d/%b exp 5/%b", cw, sw, STK); end
      clear = 1; en = 1; up = 1;
      tick();
      clear = 0; en = 0;
      tests++; if ({cw, sw, ew} !== {4'd0, 1'b0, 1'b0}) begin fails++; $display("FAIL clear got %0d/%b/%b exp 0/0/0", cw, sw, ew); end
   endtask

   task automatic test_sat_down();
      logic [3:0] exp_s [3] = '{4'd0, 4'd0, 4'd0};
      logic       exp_es[3] = '{1'b0, 1'b1, 1'b1};
      logic [3:0] exp_w [3] = '{4'd0, 4'd9, 4'd8};
      logic       exp_ew[3] = '{1'b0, 1'b1, 1'b0};
      do_load(4'd1);
      en = 1; up = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if ({cs, es, mns} !== {exp_s[i], exp_es[i], 1'b1}) begin fails++; $display("FAIL sat_down%0d got %0d/%b/%b exp %0d/%b/1", i, cs, es, mns, exp_s[i], exp_es[i]); end
         tests++; if ({cw, ew} !== {exp_w[i], exp_ew[i]}) begin fails++; $display("FAIL wrap_down%0d got %0d/%b exp %0d/%b", i, cw, ew, exp_w[i], exp_ew[i]); end
      end
      tests++; if (ss !== STK) begin fails++; $display("FAIL sticky_sat got %b exp %b", ss, STK); end
      en = 0;
   endtask

   task automatic test_clamp();
      idle(); load = 1; load_val = 4'd12; en = 1; up = 1;
      tick();
      idle();
      tests++; if ({cw, ew, mxw} !== {4'd9, 1'b0, 1'b1}) begin fails++; $display("FAIL clamp_w got %0d/%b/%b exp 9/0/1", cw, ew, mxw); end
      tests++; if ({cs, es} !== {4'd9, 1'b0}) begin fails++; $display("FAIL clamp_s got %0d/%b exp 9/0", cs, es); end
   endtask

   task automatic test_dir_change();
      do_load(4'd3);
      en = 1; up = 1; tick();
      tests++; if (cw !== 4'd4) begin fails++; $display("FAIL dir_up got %0d exp 4", cw); end
      up = 0; tick();
      tests++; if (cw !== 4'd3) begin fails++; $display("FAIL dir_dn got %0d exp 3", cw); end
      up = 1; tick();
      tests++; if (cw !== 4'd4) begin fails++; $display("FAIL dir_up2 got %0d exp 4", cw); end
      en = 0; up = 0; tick();
      tests++; if (cw !== 4'd4) begin fails++; $display("FAIL dir_hold got %0d exp 4", cw); end
   endtask

   task automatic test_priority();
      do_load(4'd9);
      en = 1; up = 1; tick();
      en = 0;
      do_load(4'd8);
      tests++; if ({cw, sw} !== {4'd8, STK}) begin fails++; $display("FAIL pri_pre got %0d/%b exp 8/%b", cw, sw, STK); end
      rst = 1; clear = 1; load = 1; load_val = 4'd6; en = 1; up = 1;
      tick();
      idle();
      tests++; if ({cw, ew, sw} !== {4'd3, 1'b0, 1'b0}) begin fails++; $display("FAIL pri_rst_w got %0d/%b/%b exp 3/0/0", cw, ew, sw); end
      tests++; if ({cs, es, ss} !== {4'd3, 1'b0, 1'b0}) begin fails++; $display("FAIL pri_rst_s got %0d/%b/%b exp 3/0/0", cs, es, ss); end
      clear = 1; load = 1; load_val = 4'd6; en = 1;
      tick();
      idle();
      tests++; if (cw !== 4'd0) begin fails++; $display("FAIL pri_clear got %0d exp 0", cw); end
   endtask

   initial begin
      idle();
      test_reset();
      test_wrap_up();
      test_sticky();
      test_sat_down();
      test_clamp();
      test_dir_change();
      test_priority();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
